// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control sequencer: fetch/decode/execute/writeback plus handshaked I/O-bus states.
// Optional macro IO_TIMEOUT_EN adds an abort-to-FAULT timer on the I/O wait states.
module multicycle_ctrl_fsm #(
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               Zero,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               InputSRC,
  output logic               OutputSRC,
  output logic               in_ack,
  output logic               out_valid,
  output logic               fault,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_IOIN   = 4'd10,
    S_IOOUT  = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       input_src;
    logic       output_src;
    logic       out_valid;
    logic       fault;
  } ctrl_t;

  state_t state, next_state;
  ctrl_t  ctrl_q, ctrl_d;
  logic   r_legal;
  logic   io_expired;
  logic   io_in_hs;

  assign r_legal = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b110) ||
                   (funct3 == 3'b111) || ((funct3 == 3'b101) && funct7_5);

  // Timer for I/O waits; counts cycles spent in IOIN/IOOUT without a handshake.
`ifdef IO_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(IO_TIMEOUT + 1);
  logic [TO_W-1:0] io_cnt;
  logic            io_wait;

  assign io_wait    = ((state == S_IOIN) && !in_valid) || ((state == S_IOOUT) && !out_ready);
  assign io_expired = (io_cnt == TO_W'(IO_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_cnt <= '0;
    end else if (io_wait && !io_expired) begin
      io_cnt <= io_cnt + TO_W'(1);
    end else begin
      io_cnt <= '0;
    end
  end
`else
  assign io_expired = 1'b0;
  // IO_TIMEOUT only matters when the timer is built.
  if (IO_TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
    end
  end

  // Next state, then the Moore controls of that state so they are registered alongside it.
  always_comb begin
    next_state = state;
    ctrl_d     = '0;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) next_state = S_MEMADR;
        else if (op == OP_R)                next_state = r_legal ? S_EXECR : S_FAULT;
        else if (op == OP_BEQ)              next_state = S_BEQ;
        else                                next_state = S_FAULT;
      end
      S_MEMADR: begin
        if (op == OP_LW) next_state = (funct3 == 3'b111) ? S_IOIN : S_MEMRD;
        else             next_state = (funct3 == 3'b111) ? S_IOOUT : S_MEMWR;
      end
      S_MEMRD:  next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = S_FETCH;
      S_EXECR:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BEQ:    next_state = S_FETCH;
      S_IOIN: begin
        if (in_valid)        next_state = S_FETCH;
        else if (io_expired) next_state = S_FAULT;
      end
      S_IOOUT: begin
        if (out_ready)       next_state = S_FETCH;
        else if (io_expired) next_state = S_FAULT;
      end
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase

    case (next_state)
      S_FETCH: begin
        ctrl_d.ir_write   = 1'b1;
        ctrl_d.alu_src_b  = 2'b10;
        ctrl_d.result_src = 2'b10;
        ctrl_d.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.imm_src   = 2'b10;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMRD: ctrl_d.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl_d.result_src = 2'b01;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl_d.alu_src_a = 2'b10;
        case (funct3)
          3'b000:  ctrl_d.alu_control = funct7_5 ? 3'b001 : 3'b000;
          3'b010:  ctrl_d.alu_control = 3'b101;
          3'b110:  ctrl_d.alu_control = 3'b011;
          3'b111:  ctrl_d.alu_control = 3'b010;
          3'b101:  ctrl_d.alu_control = 3'b110;
          default: ctrl_d.alu_control = 3'b000;
        endcase
      end
      S_ALUWB: ctrl_d.reg_write = 1'b1;
      S_BEQ: begin
        ctrl_d.alu_src_a   = 2'b10;
        ctrl_d.alu_control = 3'b001;
        ctrl_d.branch      = 1'b1;
      end
      S_IOIN: begin
        ctrl_d.input_src  = 1'b1;
        ctrl_d.result_src = 2'b01;
      end
      S_IOOUT: begin
        ctrl_d.output_src = 1'b1;
        ctrl_d.out_valid  = 1'b1;
      end
      S_FAULT: ctrl_d.fault = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // Input handshake is the only path where in_valid reaches outputs directly.
  assign io_in_hs   = (state == S_IOIN) && in_valid;

  assign PCWrite    = ctrl_q.pc_update | (ctrl_q.branch & Zero);
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = ctrl_q.ir_write;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write | io_in_hs;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ImmSrc     = ctrl_q.imm_src;
  assign ALUControl = ctrl_q.alu_control;
  assign InputSRC   = ctrl_q.input_src;
  assign OutputSRC  = ctrl_q.output_src;
  assign in_ack     = io_in_hs;
  assign out_valid  = ctrl_q.out_valid;
  assign fault      = ctrl_q.fault;
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized instruction stream for multicycle_ctrl_fsm, compared cycle by cycle to a state-trace model.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TO = 4;
`ifdef IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, Zero, in_valid, out_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       InputSRC, OutputSRC, in_ack, out_valid, fault;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl_fsm #(.STATE_W(4), .IO_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .in_valid(in_valid), .out_ready(out_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .InputSRC(InputSRC), .OutputSRC(OutputSRC),
    .in_ack(in_ack), .out_valid(out_valid), .fault(fault), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {state_dbg, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, ALUControl, InputSRC, OutputSRC, in_ack, out_valid, fault, 7'd0};
  endfunction

  function automatic bit r_ok(input logic [2:0] f3, input logic f7);
    return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7) || (f3 == 3'd5 && f7);
  endfunction

  // Control outputs expected while the sequencer sits in state `code`.
  function automatic logic [31:0] exp_vec(input int code, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic iv);
    logic pcw, adr, irw, mw, rw, isrc, osrc, ack, ov, flt;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, irw, mw, rw, isrc, osrc, ack, ov, flt} = '0;
    {rs, sa, sb, imm} = '0;
    alu = 3'd0;
    case (code)
      1: begin irw = 1; sb = 2'd2; rs = 2'd2; pcw = 1; end
      2: begin sa = 2'd1; sb = 2'd1; imm = 2'd2; end
      3: begin sa = 2'd2; sb = 2'd1; imm = (o == OP_SW) ? 2'd1 : 2'd0; end
      4: adr = 1;
      5: begin rs = 2'd1; rw = 1; end
      6: begin adr = 1; mw = 1; end
      7: begin
        sa = 2'd2;
        case (f3)
          3'd0: alu = f7 ? 3'd1 : 3'd0;
          3'd2: alu = 3'd5;
          3'd6: alu = 3'd3;
          3'd7: alu = 3'd2;
          3'd5: alu = 3'd6;
          default: alu = 3'd0;
        endcase
      end
      8: rw = 1;
      9: begin sa = 2'd2; alu = 3'd1; pcw = z; end
      10: begin isrc = 1; rs = 2'd1; rw = iv; ack = iv; end
      11: begin osrc = 1; ov = 1; end
      12: flt = 1;
      default: ;
    endcase
    return {4'(code), pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, isrc, osrc, ack, ov, flt, 7'd0};
  endfunction

  // Called a little after a clock edge or mid-cycle; returns at posedge+1 in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    #1;
    check_eq("reset_async", obs_vec(), exp_vec(0, op, funct3, funct7_5, Zero, in_valid));
    @(posedge clk); #1;
    check_eq("reset_hold", obs_vec(), exp_vec(0, op, funct3, funct7_5, Zero, in_valid));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("init", obs_vec(), exp_vec(0, op, funct3, funct7_5, Zero, in_valid));
    @(posedge clk); #1;
  endtask

  // One instruction from FETCH; wait_n = cycles the I/O partner stalls before the handshake.
  task automatic run_instr(input logic [6:0] i_op, input logic [2:0] i_f3, input logic i_f7,
                           input int wait_n, input logic i_zero, input int abort_after);
    int seq[$];
    int io_idx;
    int n_io;
    bit to_fault;
    bit fault_end;
    fault_end = 1'b0;
    seq = {1, 2};
    if (i_op == OP_LW || i_op == OP_SW) begin
      seq.push_back(3);
      if (i_f3 == 3'd7) begin
        to_fault = TO_EN && (wait_n >= int'(TO));
        n_io = to_fault ? int'(TO) : wait_n + 1;
        for (int k = 0; k < n_io; k++) seq.push_back((i_op == OP_LW) ? 10 : 11);
        if (to_fault) begin
          seq.push_back(12); seq.push_back(12);
          fault_end = 1'b1;
        end
      end else if (i_op == OP_LW) begin
        seq.push_back(4); seq.push_back(5);
      end else begin
        seq.push_back(6);
      end
    end else if (i_op == OP_R && r_ok(i_f3, i_f7)) begin
      seq.push_back(7); seq.push_back(8);
    end else if (i_op == OP_BEQ) begin
      seq.push_back(9);
    end else begin
      seq.push_back(12); seq.push_back(12); seq.push_back(12);
      fault_end = 1'b1;
    end

    io_idx = 0;
    for (int c = 0; c < seq.size(); c++) begin
      if (c == 0) begin
        op = i_op; funct3 = i_f3; funct7_5 = i_f7;
      end
      Zero = i_zero;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (seq[c] == 10) in_valid  = (io_idx == wait_n);
      if (seq[c] == 11) out_ready = (io_idx == wait_n);
      @(negedge clk);
      check_eq($sformatf("op%b_f%0d_c%0d_s%0d", i_op, i_f3, c, seq[c]), obs_vec(),
               exp_vec(seq[c], i_op, i_f3, i_f7, i_zero, in_valid));
      if (seq[c] == 10 || seq[c] == 11) io_idx++;
      if (c == abort_after) return;
      @(posedge clk); #1;
    end
    if (fault_end) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0] bad_f3 [4];
    logic [6:0] r_op;
    logic [2:0] r_f3;
    logic       r_f7;
    int         sel;
    legal_f3 = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd5};
    bad_f3   = '{3'd1, 3'd3, 3'd4, 3'd5};
    rst_n = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    Zero = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    do_reset();

    run_instr(OP_LW,  3'd2, 1'b0, 0, 1'b0, -1);
    run_instr(OP_R,   3'd0, 1'b1, 0, 1'b0, -1);
    run_instr(OP_BEQ, 3'd0, 1'b0, 0, 1'b1, -1);
    run_instr(OP_BEQ, 3'd0, 1'b0, 0, 1'b0, -1);
    run_instr(OP_LW,  3'd7, 1'b0, 3, 1'b0, -1);
    run_instr(OP_SW,  3'd7, 1'b0, 4, 1'b0, -1);
    run_instr(OP_SW,  3'd2, 1'b0, 0, 1'b0, -1);
    run_instr(OP_R,   3'd5, 1'b0, 0, 1'b0, -1);
    run_instr(OP_LW,  3'd7, 1'b0, 6, 1'b0, -1);
    run_instr(OP_SW,  3'd7, 1'b0, 9, 1'b0, 5);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      sel  = int'($urandom_range(0, 7));
      r_f7 = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 6));
      r_op = OP_LW;
      case (sel)
        0: r_op = OP_LW;
        1: r_op = OP_SW;
        2: begin r_op = OP_R; r_f3 = legal_f3[$urandom_range(0, 4)]; if (r_f3 == 3'd5) r_f7 = 1'b1; end
        3: begin r_op = OP_R; r_f3 = bad_f3[$urandom_range(0, 3)]; if (r_f3 == 3'd5) r_f7 = 1'b0; end
        4: begin r_op = OP_BEQ; r_f3 = 3'($urandom_range(0, 7)); end
        5: begin r_op = OP_LW; r_f3 = 3'd7; end
        6: begin r_op = OP_SW; r_f3 = 3'd7; end
        default: begin
          r_op = 7'($urandom_range(0, 127));
          while (r_op == OP_LW || r_op == OP_SW || r_op == OP_R || r_op == OP_BEQ)
            r_op = 7'($urandom_range(0, 127));
        end
      endcase
      run_instr(r_op, r_f3, r_f7, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
